// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
//
// Serializing UART transmitter for the guesser board. Accepts one ASCII guess
// byte per valid/ready handshake and shifts it out as a UART frame:
// start bit (0), eight data bits LSB first, an optional even-parity bit and
// one stop bit (1). A one-entry holding register lets the producer queue the
// next byte while the current frame is still on the line. A frame that ends
// with the holding register full is followed immediately by the next start
// bit, with no idle gap between the two frames.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (must be >= 2)
//   PARITY_EN    - 1 inserts an even-parity bit after data bit 7, 0 omits it
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   nRst      in   asynchronous active-low reset
//   tx_byte   in   [7:0] byte to send, sampled only on acceptance
//   tx_valid  in   producer has a byte on tx_byte
//   tx_ready  out  holding register empty; accept when tx_valid && tx_ready
//   tx_serial out  serial line, idle high, driven straight from a flop
//   tx_busy   out  high while a frame is on the line (START through STOP)
//   tx_done   out  one-cycle pulse after the stop bit of a frame completes
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 100,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    // The baud counter only has to reach CLKS_PER_BIT-1.
    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic [7:0]       hold_data;
    logic             hold_full;
    logic             bit_end;

    // High on the last clock of the current serial bit.
    assign bit_end = (baud_cnt == CNT_MAX);

    // Single registered FSM. tx_serial, tx_busy, tx_ready and tx_done are
    // all assigned here so they come straight from flops and never glitch.
    // tx_serial is written together with the state change, so the line
    // already carries the new bit value in the first cycle of that bit.
    //
    // Parity is captured from the byte at load time: the shift register is
    // destroyed as it shifts, so it cannot be used to recompute parity later.
    //
    // The acceptance branch and the load branches never fire on the same
    // edge, because acceptance needs tx_ready=1 (holding register empty)
    // while a load needs the holding register full.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            hold_data  <= 8'h00;
            hold_full  <= 1'b0;
            tx_ready   <= 1'b1;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (tx_valid && tx_ready) begin
                hold_data <= tx_byte;
                hold_full <= 1'b1;
                tx_ready  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    baud_cnt  <= '0;
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    if (hold_full) begin
                        shift_reg  <= hold_data;
                        parity_bit <= ^hold_data;
                        hold_full  <= 1'b0;
                        tx_ready   <= 1'b1;
                        bit_idx    <= 3'd0;
                        state      <= START;
                        tx_serial  <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        state     <= DATA;
                        tx_serial <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                state     <= PARITY;
                                tx_serial <= parity_bit;
                            end else begin
                                state     <= STOP;
                                tx_serial <= 1'b1;
                            end
                        end else begin
                            // Next data bit is the one about to reach bit 0.
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_serial <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        state     <= STOP;
                        tx_serial <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_done  <= 1'b1;
                        if (hold_full) begin
                            // Queued byte: go straight into its start bit.
                            shift_reg  <= hold_data;
                            parity_bit <= ^hold_data;
                            hold_full  <= 1'b0;
                            tx_ready   <= 1'b1;
                            bit_idx    <= 3'd0;
                            state      <= START;
                            tx_serial  <= 1'b0;
                            tx_busy    <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            tx_serial <= 1'b1;
                            tx_busy   <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    baud_cnt  <= '0;
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serializing UART transmitter on the guesser board. It takes one ASCII guess byte per handshake from the keypad/letter-select logic and drives the `rx_serial` line of the host board's receive path. It generates start, data (LSB first), optional even parity and stop bits. A one-entry holding register lets the producer queue the next byte while the current frame shifts out.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 100: clock cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, default 1: 1 inserts an even-parity bit after data bit 7; 0 omits it.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `nRst` input 1: asynchronous, active-low reset.
- `tx_byte` input 8: byte to send; sampled only on acceptance.
- `tx_valid` input 1: producer has a byte on `tx_byte`.
- `tx_ready` output 1: holding register empty; byte accepted on any edge where `tx_valid && tx_ready`.
- `tx_serial` output 1: serial line, idle high; registered, glitch-free.
- `tx_busy` output 1: high while a frame is on the line (START through STOP).
- `tx_done` output 1: one-cycle pulse when a frame's stop bit completes.

## Operation

- Reset values: `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; state IDLE, holding register empty, counters 0.
- Holding register (`hold_data`, `hold_full`):
  - Set on acceptance.
  - Cleared on the edge where its contents move into the shift register.
  - `tx_ready` = !`hold_full`, registered.
  - `tx_byte` changes while `tx_ready`=0 are ignored.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: `tx_serial`=1. If `hold_full`, the next edge loads the shift register, clears `hold_full` and enters START.
  - START: `tx_serial`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx_serial`=shift[0]. Shift right every CLKS_PER_BIT cycles. A 3-bit bit index counts 0..7; after bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: `tx_serial`= XOR of the 8 loaded data bits (even parity), for CLKS_PER_BIT cycles.
  - STOP: `tx_serial`=1 for CLKS_PER_BIT cycles. On the final edge, pulse `tx_done`. If `hold_full`, load the shift register and enter START directly with no idle gap; otherwise go to IDLE.
- Parity is computed from the loaded shift value at load time and stored; it is not recomputed from the shifting register.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
- `tx_busy` = state ≠ IDLE.

## Timing

- Acceptance edge k with IDLE and holding register empty:
  - `hold_full`=1 and `tx_ready`=0 from k.
  - Edge k+1 enters START; `tx_serial` falls after k+1; `tx_ready` returns to 1 after k+1.
- Frame length: (10+PARITY_EN)×CLKS_PER_BIT cycles, measured from the start-bit falling edge to the end of the stop bit.
- `tx_done` is high for exactly the one cycle following the final STOP edge.
- Back-to-back:
  - A byte accepted during frame N is started on the edge ending N's stop bit.
  - The next start bit follows N's stop bit with zero extra cycles.
  - `tx_busy` stays 1 throughout.
- Simultaneous events:
  - Acceptance and load cannot collide, because acceptance requires the holding register to be empty.
  - `tx_valid` held high with `tx_ready`=0 has no effect.
- Reset mid-frame: all outputs return to reset values asynchronously. Shift and holding contents are discarded. No `tx_done` is issued for the aborted frame.

## Test plan

Run with CLKS_PER_BIT=4, PARITY_EN=1 unless stated.

- Reset with `tx_valid`=0: `tx_serial`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0 for 20 cycles.
- Send 0x41 ('A'):
  - Line shows 0,1,0,0,0,0,0,1,0,0,1, each bit exactly 4 cycles, 44 cycles total.
  - Parity bit is 0.
  - `tx_done` pulses once; the bench's UART_Rx model decodes 0x41 with no error.
- Send 0x07: parity bit is 1; the data bits appear as 1,1,1,0,0,0,0,0.
- Back-to-back 0x48 then 0x49, where the second is accepted 2 cycles after the first frame starts:
  - `tx_ready` is low only between acceptance and the next load.
  - The second start bit begins the cycle after the first stop bit ends.
  - Two `tx_done` pulses, 44 cycles apart.
- PARITY_EN=0, send 0xFF: 40-cycle frame of 0, then eight 1s, then stop bit 1.
- Assert `nRst` low mid-DATA of 0x55:
  - `tx_serial` goes to 1 immediately and `tx_ready`=1.
  - No `tx_done` pulse.
  - A subsequent 0x55 transmits a complete, correct frame.
